bank_addr_sched: RTL
====================

BANK_ADDR_SCHED -- requirements
Module: bank_addr_sched

Interface
REQ-001 Parameter ADDR_W, default 7: bank word-address width; 2**ADDR_W words per bank.
REQ-002 Parameter NUM_STAGES, default 9: number of full passes over the banks per job, valid range 1..16.
REQ-003 Parameter WB_LAT, default 3: cycles from rd_en to the matching wr_en, valid range 1..8.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 start  input  1: single-cycle job request; sampled only in IDLE.
REQ-007 stall  input  1: downstream back-pressure; freezes address generation while high.
REQ-008 b0, b1, b2, b3  output  ADDR_W each: per-bank word addresses for the 4-bank address crossbar.
REQ-009 sel_a_0, sel_a_1, sel_a_2, sel_a_3  output  2 each: crossbar selects, lane k takes bank sel_a_k.
REQ-010 rd_en  output  1: the address set on b*/sel_a_* this cycle is valid.
REQ-011 addr_vld  output  1: rd_en delayed 1 cycle, aligned with the registered crossbar output.
REQ-012 wr_en  output  1: rd_en delayed WB_LAT cycles; write-back strobe.
REQ-013 stage  output  4: current stage index.
REQ-014 busy  output  1: high in every state except IDLE.
REQ-015 done  output  1: one-cycle pulse at job completion.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
- IDLE to RUN on start.
- RUN to DRAIN when the last issue of the last stage is accepted.
- DRAIN to DONE after WB_LAT cycles.
- DONE to IDLE after 1 cycle.
REQ-017 Counters SHALL be cnt (ADDR_W bits) and stage (4 bits); both are cleared on the IDLE-to-RUN transition.
REQ-018 An issue SHALL occur when state is RUN and stall is 0. On each issue:
- rd_en is 1.
- cnt increments.
- When cnt is 2**ADDR_W-1, cnt wraps to 0 and stage increments.
REQ-019 When state is RUN and stall is 1:
- rd_en SHALL be 0.
- cnt, stage, b* and sel_a_* SHALL hold.
REQ-020 Outputs b0..b3 SHALL all equal cnt.
REQ-021 Selects SHALL be computed as follows:
- rot = (cnt[1:0] + stage[1:0]) mod 4, with 2-bit wrap and no carry.
- sel_a_k = (k + rot) mod 4.
- The four selects are therefore always a permutation of 0..3, so there is never a bank conflict.
REQ-022 The last issue is cnt = 2**ADDR_W-1 with stage = NUM_STAGES-1. On that issue, stage SHALL stay at NUM_STAGES-1 rather than increment, and the FSM enters DRAIN.
REQ-023 Outputs b*, sel_a_* and rd_en SHALL be driven combinationally from the registered cnt/stage/state, so there is zero latency from issue to the crossbar inputs.
REQ-024 addr_vld SHALL equal rd_en delayed by exactly 1 cycle; wr_en SHALL equal rd_en delayed by exactly WB_LAT cycles.
REQ-025 The stall input SHALL NOT gate the delay lines; stall only suppresses new issues.
REQ-026 done SHALL be 1 only in the DONE state. The cycle done is high SHALL be WB_LAT+1 cycles after the last rd_en, so the last wr_en precedes done by 1 cycle.
REQ-027 start SHALL be ignored in RUN, DRAIN and DONE; it is not queued.
REQ-028 If start and stall are both high in IDLE, the FSM SHALL enter RUN, and the first issue waits until stall falls.
REQ-029 Total issues per job SHALL be exactly NUM_STAGES * 2**ADDR_W, independent of the stall pattern.

Reset
REQ-030 When rst is 1 at a clock edge, the following SHALL be cleared:
- state to IDLE.
- cnt, stage, b*, sel_a_* to 0.
- rd_en, addr_vld, wr_en, busy, done to 0.
- all delay-line bits to 0.
REQ-031 Reset asserted mid-job SHALL abort the job with no done pulse. No wr_en SHALL appear after the reset edge.

Structure
REQ-032 A shared package SHALL hold:
- the FSM state enumeration (2-bit encoding).
- NUM_BANKS = 4 and the select width of 2.
- defaults for ADDR_W, NUM_STAGES and WB_LAT.
REQ-033 The delay lines SHALL be built from the existing DFF sub-module, instantiated with width 1 and chained: 1 stage for addr_vld, WB_LAT stages for wr_en.
REQ-034 There SHALL be no other sub-modules.

Verification
REQ-035 Basic job (ADDR_W=2, NUM_STAGES=2, WB_LAT=3, start at cycle 0, no stall):
- rd_en is high for cycles 1..8.
- Cycle 1: b* = 0, sel_a = (0,1,2,3).
- Cycle 5: stage = 1, sel_a = (1,2,3,0).
- wr_en is high for cycles 4..11.
- done is high at cycle 12.
- busy falls at cycle 13.
REQ-036 Stall (stall high for cycles 3..4 in the REQ-035 setup):
- rd_en is low in cycles 3..4, and b* holds at 2.
- Total rd_en count is 8.
- done moves to cycle 14.
REQ-037 start pulsed in cycle 6 of a running job: no effect, and the issue count stays 8.
REQ-038 rst in cycle 5 of a job:
- The next cycle shows IDLE with all outputs 0.
- No wr_en or done follows.
- A new start then runs the full job.
REQ-039 Default parameters, random stall:
- Check 9*128 = 1152 rd_en pulses.
- The sel_a_* values are a permutation on every issue.
- rot matches REQ-021.

Source files
------------

// File: rtl/bank_addr_sched_pkg.sv
// Shared types and constants for the 4-bank address scheduler.
// Holds FSM encoding, bank geometry and parameter defaults.
package bank_addr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_BANKS      = 4;
    localparam int SEL_W          = 2;
    localparam int DEF_ADDR_W     = 7;
    localparam int DEF_NUM_STAGES = 9;
    localparam int DEF_WB_LAT     = 3;

    // Lane k reads bank (k + rot) mod 4; the 2-bit add wraps naturally.
    function automatic logic [SEL_W-1:0] lane_sel(
        input logic [SEL_W-1:0] k,
        input logic [SEL_W-1:0] rot
    );
        return k + rot;
    endfunction

endpackage

// File: rtl/bank_addr_sched_dff.sv
// Plain W-bit register with synchronous active-high clear.
// Used as the building block of the rd_en delay lines.
module bank_addr_sched_dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= d;
    end

endmodule

// File: rtl/bank_addr_sched.sv
// Conflict-free rotating address scheduler for a 4-bank memory.
// Walks every word once per stage, then drains the write-back pipe.
import bank_addr_sched_pkg::*;

module bank_addr_sched #(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int WB_LAT     = DEF_WB_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic [ADDR_W-1:0] b0,
    output logic [ADDR_W-1:0] b1,
    output logic [ADDR_W-1:0] b2,
    output logic [ADDR_W-1:0] b3,
    output logic [SEL_W-1:0]  sel_a_0,
    output logic [SEL_W-1:0]  sel_a_1,
    output logic [SEL_W-1:0]  sel_a_2,
    output logic [SEL_W-1:0]  sel_a_3,
    output logic              rd_en,
    output logic              addr_vld,
    output logic              wr_en,
    output logic [3:0]        stage,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] CNT_MAX    = '1;
    localparam logic [3:0]        LAST_STAGE = 4'(NUM_STAGES - 1);
    localparam logic [3:0]        DRAIN_LAST = 4'(WB_LAT - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [3:0]        stg;
    logic [3:0]        dcnt;
    logic [SEL_W-1:0]  rot;
    logic [SEL_W-1:0]  sel [NUM_BANKS];
    logic [WB_LAT:0]   wb_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            stg   <= '0;
            dcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                        stg   <= '0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        cnt <= cnt + ADDR_W'(1);
                        if (cnt == CNT_MAX) begin
                            // Last stage holds its index; the job moves on to drain.
                            if (stg == LAST_STAGE) begin
                                state <= DRAIN;
                                dcnt  <= '0;
                            end else begin
                                stg <= stg + 4'd1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (dcnt == DRAIN_LAST) state <= DONE;
                    else                    dcnt  <= dcnt + 4'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_en = (state == RUN) && !stall;
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign stage = stg;

    assign b0 = cnt;
    assign b1 = cnt;
    assign b2 = cnt;
    assign b3 = cnt;

    assign rot = cnt[1:0] + stg[1:0];

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_sel
        assign sel[k] = (state == IDLE) ? '0 : lane_sel(SEL_W'(k), rot);
    end

    assign sel_a_0 = sel[0];
    assign sel_a_1 = sel[1];
    assign sel_a_2 = sel[2];
    assign sel_a_3 = sel[3];

    bank_addr_sched_dff #(.W(1)) u_vld (
        .clk (clk),
        .rst (rst),
        .d   (rd_en),
        .q   (addr_vld)
    );

    assign wb_pipe[0] = rd_en;

    for (genvar i = 0; i < WB_LAT; i++) begin : g_wb
        bank_addr_sched_dff #(.W(1)) u_dff (
            .clk (clk),
            .rst (rst),
            .d   (wb_pipe[i]),
            .q   (wb_pipe[i+1])
        );
    end

    assign wr_en = wb_pipe[WB_LAT];

endmodule
